// File: rtl/keypad_scan_if.sv
// Keypad pins and the debounced key code, grouped as one bundle.
// The master side is the keypad/host; the slave side is the scanner.
interface keypad_scan_if;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] onehot;
    logic        key_event;

    modport master (output row, input col, input onehot, input key_event);
    modport slave  (input row, output col, output onehot, output key_event);
endinterface

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: drives one column low at a time, samples the rows at
// the end of each column dwell, and debounces whole-keypad snapshots.
// A snapshot is committed once it has been seen DEBOUNCE_SWEEPS+1 times in a
// row; single-key commits update onehot, empty commits clear it, and
// multi-key (possible ghost) commits leave it untouched.
//
// Column scan FSM
//   state | meaning
//   COL0  | column 0 driven low
//   COL1  | column 1 driven low
//   COL2  | column 2 driven low
//   COL3  | column 3 driven low; its last dwell cycle is the sweep end
module keypad_scan #(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_SWEEPS = 5
) (
    input  logic         clk,
    input  logic         RSTn,
    keypad_scan_if.slave kp
);

    localparam int              DW         = $clog2(SCAN_DIV);
    localparam logic [DW-1:0]   DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [3:0]      DEB_TARGET = 4'(DEBOUNCE_SWEEPS);

    typedef enum logic [1:0] {
        COL0 = 2'd0,
        COL1 = 2'd1,
        COL2 = 2'd2,
        COL3 = 2'd3
    } col_state_t;

    col_state_t    r_state;
    col_state_t    w_state_next;

    logic [3:0]    r_row_meta;
    logic [3:0]    r_row_s;
    logic [DW-1:0] r_dwell;
    logic [3:0]    r_col;
    logic [3:0]    w_col_next;
    logic [15:0]   r_snap_work;
    logic [15:0]   w_snap_next;
    logic [15:0]   r_snap_prev;
    logic [3:0]    r_deb_cnt;
    logic          r_commit;
    logic [15:0]   r_commit_snap;
    logic [15:0]   r_onehot;
    logic [15:0]   w_onehot_next;
    logic          r_key_event;

    logic          w_dwell_last;
    logic          w_sweep_end;
    logic          w_snap_match;
    logic          w_commit;
    logic          w_one_bit;

    assign w_dwell_last = (r_dwell == DWELL_LAST);
    assign w_sweep_end  = w_dwell_last && (r_state == COL3);
    assign w_snap_match = (w_snap_next == r_snap_prev);
    // The commit fires only on the transition into saturation, so a long
    // stable run produces exactly one commit.
    assign w_commit     = w_sweep_end && w_snap_match && (r_deb_cnt == DEB_TARGET - 4'd1);
    assign w_one_bit    = (r_commit_snap != 16'h0000) &&
                          ((r_commit_snap & (r_commit_snap - 16'd1)) == 16'h0000);

    // Two-flop synchronizer; rows idle high so reset loads all ones.
    always_ff @(posedge clk) begin
        if (RSTn) begin
            r_row_meta <= 4'b1111;
            r_row_s    <= 4'b1111;
        end else begin
            r_row_meta <= kp.row;
            r_row_s    <= r_row_meta;
        end
    end

    // Column dwell timer.
    always_ff @(posedge clk) begin
        if (RSTn) begin
            r_dwell <= '0;
        end else if (w_dwell_last) begin
            r_dwell <= '0;
        end else begin
            r_dwell <= r_dwell + DW'(1);
        end
    end

    // Column FSM state and registered column drive.
    always_ff @(posedge clk) begin
        if (RSTn) begin
            r_state <= COL0;
            r_col   <= 4'b1110;
        end else begin
            r_state <= w_state_next;
            r_col   <= w_col_next;
        end
    end

    // Next column on dwell wrap, and its active-low drive pattern.
    always_comb begin
        w_state_next = r_state;
        w_col_next   = 4'b1110;
        if (w_dwell_last) begin
            case (r_state)
                COL0: w_state_next = COL1;
                COL1: w_state_next = COL2;
                COL2: w_state_next = COL3;
                COL3: w_state_next = COL0;
            endcase
        end
        case (w_state_next)
            COL0: w_col_next = 4'b1110;
            COL1: w_col_next = 4'b1101;
            COL2: w_col_next = 4'b1011;
            COL3: w_col_next = 4'b0111;
        endcase
    end

    // Working snapshot with the current column's row sample merged in.
    always_comb begin
        w_snap_next = r_snap_work;
        for (int r = 0; r < 4; r++) begin
            case (r_state)
                COL0: w_snap_next[4*r]     = ~r_row_s[r];
                COL1: w_snap_next[4*r + 1] = ~r_row_s[r];
                COL2: w_snap_next[4*r + 2] = ~r_row_s[r];
                COL3: w_snap_next[4*r + 3] = ~r_row_s[r];
            endcase
        end
    end

    // Snapshot capture at the end of each column dwell.
    always_ff @(posedge clk) begin
        if (RSTn) begin
            r_snap_work <= 16'h0000;
        end else if (w_dwell_last) begin
            r_snap_work <= w_snap_next;
        end
    end

    // Sweep-to-sweep comparison and saturating debounce count.
    always_ff @(posedge clk) begin
        if (RSTn) begin
            r_snap_prev <= 16'h0000;
            r_deb_cnt   <= 4'd0;
        end else if (w_sweep_end) begin
            r_snap_prev <= w_snap_next;
            if (!w_snap_match) begin
                r_deb_cnt <= 4'd0;
            end else if (r_deb_cnt != DEB_TARGET) begin
                r_deb_cnt <= r_deb_cnt + 4'd1;
            end
        end
    end

    // Commit request staged one cycle ahead of the output update.
    always_ff @(posedge clk) begin
        if (RSTn) begin
            r_commit      <= 1'b0;
            r_commit_snap <= 16'h0000;
        end else begin
            r_commit <= w_commit;
            if (w_commit) begin
                r_commit_snap <= w_snap_next;
            end
        end
    end

    // Output selection: single key loads, empty clears, multi-key holds.
    always_comb begin
        w_onehot_next = r_onehot;
        if (r_commit) begin
            if (r_commit_snap == 16'h0000) begin
                w_onehot_next = 16'h0000;
            end else if (w_one_bit) begin
                w_onehot_next = r_commit_snap;
            end
        end
    end

    // Registered key code and new-key pulse.
    always_ff @(posedge clk) begin
        if (RSTn) begin
            r_onehot    <= 16'h0000;
            r_key_event <= 1'b0;
        end else begin
            r_onehot    <= w_onehot_next;
            r_key_event <= (w_onehot_next != r_onehot) && (w_onehot_next != 16'h0000);
        end
    end

    assign kp.col       = r_col;
    assign kp.onehot    = r_onehot;
    assign kp.key_event = r_key_event;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_SWEEPS=2. A keypad model
// pulls rows low for pressed keys on the driven column. Key sets change at
// sweep boundaries; a sweep-level model (run length of identical snapshots)
// predicts onehot and key_event for each following sweep.
module tb_keypad_scan;

    localparam int SD    = 4;
    localparam int DS    = 2;
    localparam int SWEEP = 4 * SD;
    localparam int LAT_MAX = (DS + 2) * 4 * SD + 3;

    logic        clk = 1'b0;
    logic        RSTn;
    logic [15:0] keys;
    logic [3:0]  row_v;

    int tests = 0;
    int fails = 0;

    logic [15:0] m_prev;
    int          m_run;
    logic [15:0] m_onehot;
    int          m_pulse;

    keypad_scan_if kp ();

    keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_SWEEPS(DS)) dut (
        .clk  (clk),
        .RSTn (RSTn),
        .kp   (kp)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key shorts its row to its column.
    always_comb begin
        row_v = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[4*r + c] && !kp.col[c]) row_v[r] = 1'b0;
    end
    assign kp.row = row_v;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached (tests=%0d)", tests);
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_prev   = 16'h0000;
        m_run    = 1;
        m_onehot = 16'h0000;
        m_pulse  = 0;
    endtask

    task automatic model_sweep(input logic [15:0] snap);
        int n;
        m_pulse = 0;
        if (snap == m_prev) m_run++;
        else                m_run = 1;
        m_prev = snap;
        if (m_run == DS + 1) begin
            n = $countones(snap);
            if (n == 0) begin
                m_onehot = 16'h0000;
            end else if (n == 1) begin
                if (snap != m_onehot) m_pulse = 1;
                m_onehot = snap;
            end
        end
    endtask

    // One aligned sweep: called at the falling edge of the sweep's first cycle.
    task automatic run_sweep(input logic [15:0] k, input string tag);
        int          col_bad = 0;
        int          oh_bad  = 0;
        int          pulses  = 0;
        logic [3:0]  exp_col;
        logic [15:0] bad_oh  = 16'h0000;
        keys = k;
        for (int i = 0; i < SWEEP; i++) begin
            exp_col = ~(4'b0001 << (i / SD));
            if (kp.col !== exp_col) col_bad++;
            if (kp.key_event === 1'b1) pulses++;
            if (i >= 2 && kp.onehot !== m_onehot) begin
                oh_bad++;
                bad_oh = kp.onehot;
            end
            @(negedge clk);
        end
        tests++;
        if (col_bad != 0) begin
            fails++;
            $display("FAIL %s col_sequence: %0d wrong cycles, required 0", tag, col_bad);
        end
        tests++;
        if (oh_bad != 0) begin
            fails++;
            $display("FAIL %s onehot: got %h, required %h", tag, bad_oh, m_onehot);
        end
        tests++;
        if (pulses != m_pulse) begin
            fails++;
            $display("FAIL %s key_event_count: got %0d, required %0d", tag, pulses, m_pulse);
        end
        model_sweep(k);
    endtask

    task automatic do_reset();
        @(negedge clk);
        RSTn = 1'b1;
        @(negedge clk);
        RSTn = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        keys = 16'h0000;
        RSTn = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (kp.col !== 4'b1110) begin
            fails++; $display("FAIL reset_col: got %b, required 1110", kp.col);
        end
        tests++;
        if (kp.onehot !== 16'h0000) begin
            fails++; $display("FAIL reset_onehot: got %h, required 0000", kp.onehot);
        end
        tests++;
        if (kp.key_event !== 1'b0) begin
            fails++; $display("FAIL reset_key_event: got %b, required 0", kp.key_event);
        end
        RSTn = 1'b0;
        model_reset();
    endtask

    task automatic test_idle();
        for (int s = 0; s < 20; s++) run_sweep(16'h0000, "idle");
    endtask

    task automatic test_press();
        for (int s = 0; s < 5; s++) run_sweep(16'h0100, "press");
    endtask

    task automatic test_glitch();
        for (int s = 0; s < 4; s++) run_sweep(16'h0000, "glitch_idle");
        run_sweep(16'h0100, "glitch_press");
        run_sweep(16'h0100, "glitch_press");
        run_sweep(16'h0000, "glitch_bounce");
        for (int s = 0; s < 5; s++) run_sweep(16'h0100, "glitch_settle");
    endtask

    task automatic test_multi();
        for (int s = 0; s < 5; s++) run_sweep(16'h0108, "multi_hold");
        for (int s = 0; s < 5; s++) run_sweep(16'h0008, "multi_release");
    endtask

    task automatic test_release();
        for (int s = 0; s < 5; s++) run_sweep(16'h0000, "release");
    endtask

    task automatic test_back_to_back();
        for (int s = 0; s < 4; s++) run_sweep(16'h0008, "b2b_first");
        for (int s = 0; s < 4; s++) run_sweep(16'h4000, "b2b_second");
    endtask

    task automatic test_reset_mid();
        for (int s = 0; s < 4; s++) run_sweep(16'h0008, "mid_setup");
        run_sweep(16'h0100, "mid_press");
        run_sweep(16'h0100, "mid_press");
        repeat (6) @(negedge clk);
        RSTn = 1'b1;
        @(negedge clk);
        tests++;
        if (kp.onehot !== 16'h0000) begin
            fails++; $display("FAIL mid_reset_onehot: got %h, required 0000", kp.onehot);
        end
        tests++;
        if (kp.col !== 4'b1110) begin
            fails++; $display("FAIL mid_reset_col: got %b, required 1110", kp.col);
        end
        RSTn = 1'b0;
        model_reset();
        for (int s = 0; s < 5; s++) run_sweep(16'h0100, "mid_after");
    endtask

    task automatic test_latency();
        int cyc    = 0;
        int pulses = 0;
        bit seen   = 0;
        keys = 16'h0000;
        do_reset();
        for (int s = 0; s < 4; s++) run_sweep(16'h0000, "lat_idle");
        repeat ($urandom_range(0, SWEEP - 1)) @(negedge clk);
        keys = 16'h0100;
        while (!seen && cyc < LAT_MAX + 20) begin
            @(negedge clk);
            cyc++;
            if (kp.key_event === 1'b1) pulses++;
            if (kp.onehot === 16'h0100) seen = 1;
        end
        repeat (3 * SWEEP) begin
            @(negedge clk);
            if (kp.key_event === 1'b1) pulses++;
        end
        tests++;
        if (!seen || cyc > LAT_MAX) begin
            fails++;
            $display("FAIL press_latency: got %0d cycles (seen=%0d), required <= %0d", cyc, seen, LAT_MAX);
        end
        tests++;
        if (pulses != 1) begin
            fails++; $display("FAIL latency_key_event_count: got %0d, required 1", pulses);
        end
        keys = 16'h0000;
        do_reset();
    endtask

    task automatic test_random();
        logic [15:0] pat;
        int          a;
        int          b;
        int          kind;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 5);
            a    = $urandom_range(0, 15);
            b    = (a + $urandom_range(1, 15)) % 16;
            pat  = 16'h0000;
            if (kind >= 1) pat[a] = 1'b1;
            if (kind == 5) pat[b] = 1'b1;
            repeat ($urandom_range(1, 4)) run_sweep(pat, "random");
        end
        for (int s = 0; s < 4; s++) run_sweep(16'h0000, "random_end");
    endtask

    initial begin
        keys = 16'h0000;
        RSTn = 1'b1;
        model_reset();
        test_reset();
        test_idle();
        test_press();
        test_glitch();
        test_multi();
        test_release();
        test_back_to_back();
        test_reset_mid();
        test_latency();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter SCAN_DIV, default 50000, sets the clk cycles each column is driven (1 ms at 50 MHz); legal values are 4 and above.
REQ-002 Parameter DEBOUNCE_SWEEPS, default 5, sets the number of consecutive identical sweep snapshots that follow a change before that snapshot is committed; legal values are 1 to 15.
REQ-003 clk  input  1  system clock, 50 MHz nominal; the block has a single clock domain.
REQ-004 RSTn  input  1  synchronous, active-high reset.
REQ-005 row  input  4  keypad row lines, active-low (0 = pressed key on the driven column), asynchronous to clk.
REQ-006 col  output  4  keypad column drive, active-low, with exactly one bit low at any time.
REQ-007 onehot  output  16  debounced key code: bit r*4+c set for row r, column c; all zeros when no key is pressed; held while the key stays pressed.
REQ-008 key_event  output  1  one-cycle pulse when onehot takes a new non-zero value.

Function
REQ-009 row SHALL pass through a 2-flop synchronizer before any use; only the synchronized value row_s is sampled.
REQ-010 A dwell counter SHALL count 0..SCAN_DIV-1; at SCAN_DIV-1 it wraps to 0 and the column index c advances 0->1->2->3->0.
REQ-011 col SHALL equal ~(4'b0001 << c), registered, and change on the clk edge where the dwell counter wraps.
REQ-012 On the dwell-counter value SCAN_DIV-1 of column c, bits {r*4+c} of a 16-bit working snapshot SHALL be loaded with ~row_s[r] for r = 0..3.
REQ-013 Sweep end is the dwell-counter value SCAN_DIV-1 with c=3; the completed snapshot S_k is compared against the previous snapshot S_(k-1).
REQ-014 Debounce counter update at sweep end: if S_k == S_(k-1), the counter increments, saturating at DEBOUNCE_SWEEPS; otherwise it is cleared to 0; S_k is then stored as the previous snapshot.
REQ-015 Commit occurs at the sweep end on which the debounce counter reaches DEBOUNCE_SWEEPS, i.e. after DEBOUNCE_SWEEPS+1 identical consecutive snapshots following a change.
REQ-016 A commit happens once per stable run; further identical sweeps at saturation SHALL NOT re-commit or re-pulse.
REQ-017 On commit with exactly one snapshot bit set, onehot SHALL load the snapshot one cycle after sweep end.
REQ-018 On commit with zero bits set, onehot SHALL load 16'h0000.
REQ-019 On commit with two or more bits set (multi-key/ghost), onehot SHALL hold its previous value.
REQ-020 key_event SHALL be high for exactly the cycle in which onehot changes to a non-zero value, including a direct change from one non-zero code to another.
REQ-021 key_event SHALL stay low on a release to zero and on a rejected multi-key commit.
REQ-022 Worst-case press-to-onehot latency SHALL NOT exceed (DEBOUNCE_SWEEPS+2)*4*SCAN_DIV+3 cycles.
REQ-023 A bounce (any snapshot differing from its predecessor) SHALL restart the debounce count with no change to onehot.
REQ-024 onehot SHALL be glitch-free: it is registered and changes only on a commit.

Reset
REQ-025 While RSTn=1 on a clk edge: dwell counter, c, debounce counter, working snapshot and previous snapshot SHALL clear to 0.
REQ-026 On the same reset edge: col=4'b1110, onehot=16'h0000, key_event=0, and the synchronizer flops are loaded with 4'b1111.
REQ-027 Reset asserted mid-sweep or mid-debounce SHALL discard the partial scan; scanning restarts at column 0 on the first cycle after RSTn falls.

Verification (SCAN_DIV=4, DEBOUNCE_SWEEPS=2)
REQ-028 Reset then idle rows=4'b1111 for 20 sweeps -> col cycles 1110,1101,1011,0111 every 4 cycles; onehot stays 0; key_event never pulses.
REQ-029 Press row 2/col 0 held steady -> onehot=16'h0100 after the 3rd identical sweep, within (2+2)*16+3=67 cycles; exactly one key_event pulse.
REQ-030 Same press with a release glitch during one sweep, then steady -> debounce restarts and commit is delayed by the glitch; onehot never shows an intermediate value; one key_event.
REQ-031 Hold 16'h0100, then press row 0/col 3 simultaneously -> onehot holds 16'h0100 and no key_event; releasing row 2/col 0 -> onehot=16'h0008 with one key_event.
REQ-032 Release of all keys -> onehot returns to 16'h0000 after 3 identical sweeps; key_event stays 0.
REQ-033 Assert RSTn mid-debounce of a press -> onehot=0, col=1110; after release of reset with the key still held, commit follows the full 3-sweep debounce.
